aq_pump_sequencer: RTL and testbench
====================================

Name: aq_pump_sequencer

Overview:
- Sequences the shared hot/cold pump pair downstream of the aquarium temperature/humidity decision logic.
- Takes raw hot/cold requests and drives the pump outputs under these rules: mutual exclusion, minimum on-time, dead-time between runs, maximum continuous run with forced cool-down, and a water-level interlock.
- All timing is in 1 s ticks from an internal prescaler on the 50 MHz board clock.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s tick (sim uses 4).
- MIN_ON, 5, minimum run length in ticks once a pump starts (1..255).
- DEAD_TIME, 2, ticks both pumps held off after any run ends (1..255).
- MAX_ON, 60, maximum continuous run in ticks before forced cool-down (MIN_ON..255).
- COOLDOWN, 10, ticks both pumps held off after a MAX_ON expiry (1..255).

Ports:
- clk, input, 1, system clock.
- clr, input, 1, reset: asynchronous, active-high.
- req_hot, input, 1, hot pump request from decision logic.
- req_cold, input, 1, cold pump request from decision logic.
- water_ok, input, 1, 1 = water level adequate to run a pump.
- pump_hot, output, 1, hot pump drive.
- pump_cold, output, 1, cold pump drive.
- conflict, output, 1, high while idle with both requests asserted.
- dry_fault, output, 1, sticky; set when the interlock trips a running pump.
- state, output, 3, current state encoding for debug LEDs.

Behaviour:
- Reset (clr=1, async): state=IDLE, prescaler=0, tick counter=0, and all outputs 0.
- Prescaler: counts 0..TICK_DIV-1 and emits a 1-cycle tick at TICK_DIV-1.
  - Prescaler and tick counter (8 bit) clear on every state transition, so each interval is exactly N*TICK_DIV cycles from state entry.
  - Tick counter saturates at 255.
- All outputs are registered and decoded from the next state, so pump output follows the transition with 1 cycle latency.
- States and encodings: IDLE=0, RUN_HOT=1, RUN_COLD=2, DEAD=3, COOL=4.
- IDLE (pumps off):
  - water_ok=1 & req_hot=1 & req_cold=0 -> RUN_HOT.
  - water_ok=1 & req_cold=1 & req_hot=0 -> RUN_COLD.
  - Both requests high -> stay in IDLE, conflict=1 (combinational on registered state, cleared as soon as either request drops).
  - water_ok=0 -> stay in IDLE.
  - dry_fault clears in IDLE while water_ok=1.
- RUN_HOT / RUN_COLD (only the matching pump on). Priority, highest first:
  1. water_ok=0 -> DEAD with dry_fault=1. Overrides MIN_ON; the pump drops on the next cycle.
  2. count==MAX_ON -> COOL.
  3. count>=MIN_ON and (own request low or opposite request high) -> DEAD.
  4. Otherwise stay.
  - A request drop before MIN_ON has no effect until MIN_ON is reached.
- DEAD (pumps off): count==DEAD_TIME -> IDLE. Requests are ignored.
- COOL (pumps off): count==COOLDOWN -> IDLE. Requests are ignored.
- pump_hot and pump_cold are never both 1 in any cycle.
- Illegal state encodings go to IDLE on the next clock.
- clr asserted mid-run drops both pumps immediately (async) and restarts from IDLE with a full prescaler period.

Decomposition:
- Shared package aq_pkg holds:
  - the state encoding constants (ST_IDLE..ST_COOL, 3 bit);
  - the default tick constant AQ_TICK_DIV=50000000, shared with the existing 1 s evaluation counter in the aquarium controller.
- One natural sub-module, aq_tick_gen: prescaler with sync restart input and tick output, parameter TICK_DIV. It is reusable by other aquarium blocks.
- The FSM and tick counter stay in the top module.

Test Plan:
All scenarios use TICK_DIV=4, MIN_ON=3, DEAD_TIME=2, MAX_ON=6, COOLDOWN=2.
- Basic hot run:
  - Stimulus: water_ok=1; req_hot=1 at cycle 10; drop at cycle 14.
  - Response: pump_hot=1 from cycle 11 until 12 cycles after entry.
  - Then DEAD for 8 cycles, then IDLE.
  - pump_cold stays 0 throughout.
- MAX_ON:
  - Stimulus: req_cold held high.
  - Response: pump_cold on for exactly 24 cycles, then COOL with pumps off for 8 cycles.
  - Then it returns to RUN_COLD via IDLE.
- Interlock:
  - Stimulus: during RUN_HOT at count=1, water_ok drops.
  - Response: pump_hot=0 one cycle later and dry_fault=1.
  - dry_fault stays 1 through DEAD and clears in IDLE once water_ok=1.
- Conflict:
  - Stimulus: in IDLE, req_hot=req_cold=1.
  - Response: conflict=1, no pump on.
  - Releasing req_cold gives RUN_HOT next cycle and conflict=0.
- Switchover:
  - Stimulus: in RUN_HOT after MIN_ON, req_cold rises while req_hot stays high.
  - Response: DEAD for 8 cycles, then IDLE.
  - Conflict is then flagged; never both pumps on.
- Async reset:
  - Stimulus: clr pulsed mid-cycle during RUN_COLD.
  - Response: pump_cold=0 before the next clk edge, state=0.
  - Re-run timing is exact from release.

Source files
------------

// File: rtl/aq_pkg.sv
// Shared definitions for the aquarium pump blocks.
// The tick constant is also used by the controller's 1 s evaluation counter.
package aq_pkg;

    localparam int unsigned AQ_TICK_DIV = 50000000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN_HOT  = 3'd1,
        ST_RUN_COLD = 3'd2,
        ST_DEAD     = 3'd3,
        ST_COOL     = 3'd4
    } aq_state_e;

endpackage

// File: rtl/aq_tick_gen.sv
// 1 s tick prescaler with synchronous restart, usable by any aquarium block.
// tick is high for one cycle each time the count reaches TICK_DIV-1.
import aq_pkg::*;

module aq_tick_gen #(
    parameter int unsigned TICK_DIV = AQ_TICK_DIV
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Not gated by restart: the caller derives restart from tick.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/aq_pump_sequencer.sv
// Hot/cold pump sequencer: mutual exclusion, minimum on-time, dead-time,
// max run with forced cool-down, and a water-level interlock.
//
// state       | meaning
// ------------+------------------------------------------------
// ST_IDLE     | pumps off, waiting for a single request
// ST_RUN_HOT  | hot pump on
// ST_RUN_COLD | cold pump on
// ST_DEAD     | both off for DEAD_TIME ticks after a run ends
// ST_COOL     | both off for COOLDOWN ticks after a MAX_ON expiry
import aq_pkg::*;

module aq_pump_sequencer #(
    parameter int unsigned TICK_DIV  = AQ_TICK_DIV,
    parameter int unsigned MIN_ON    = 5,
    parameter int unsigned DEAD_TIME = 2,
    parameter int unsigned MAX_ON    = 60,
    parameter int unsigned COOLDOWN  = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req_hot,
    input  logic       req_cold,
    input  logic       water_ok,
    output logic       pump_hot,
    output logic       pump_cold,
    output logic       conflict,
    output logic       dry_fault,
    output logic [2:0] state
);

    localparam logic [7:0] MIN_ON_C   = 8'(MIN_ON);
    localparam logic [7:0] DEAD_C     = 8'(DEAD_TIME);
    localparam logic [7:0] MAX_ON_C   = 8'(MAX_ON);
    localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN);

    aq_state_e  state_q, state_d;
    logic [7:0] tick_cnt, elapsed;
    logic       tick, restart, dry_d, own_req, opp_req;

    assign restart = (state_d != state_q);

    aq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .tick    (tick)
    );

    // Look ahead by the current tick so an N-tick interval ends exactly
    // N*TICK_DIV cycles after state entry.
    assign elapsed = (tick && tick_cnt != 8'hFF) ? tick_cnt + 8'd1 : tick_cnt;

    assign own_req = (state_q == ST_RUN_HOT) ? req_hot  : req_cold;
    assign opp_req = (state_q == ST_RUN_HOT) ? req_cold : req_hot;

    always_comb begin
        state_d = state_q;
        dry_d   = dry_fault;
        case (state_q)
            ST_IDLE: begin
                if (water_ok) begin
                    dry_d = 1'b0;
                    if (req_hot && !req_cold)      state_d = ST_RUN_HOT;
                    else if (req_cold && !req_hot) state_d = ST_RUN_COLD;
                end
            end
            ST_RUN_HOT, ST_RUN_COLD: begin
                if (!water_ok) begin
                    state_d = ST_DEAD;
                    dry_d   = 1'b1;
                end else if (elapsed == MAX_ON_C) begin
                    state_d = ST_COOL;
                end else if (elapsed >= MIN_ON_C && (!own_req || opp_req)) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: if (elapsed == DEAD_C)     state_d = ST_IDLE;
            ST_COOL: if (elapsed == COOLDOWN_C) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            tick_cnt  <= 8'd0;
            pump_hot  <= 1'b0;
            pump_cold <= 1'b0;
            dry_fault <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_cnt  <= restart ? 8'd0 : elapsed;
            pump_hot  <= (state_d == ST_RUN_HOT);
            pump_cold <= (state_d == ST_RUN_COLD);
            dry_fault <= dry_d;
        end
    end

    assign conflict = (state_q == ST_IDLE) && req_hot && req_cold;
    assign state    = state_q;

endmodule

// File: tb/tb_aq_pump_sequencer.sv
// Directed bench for aq_pump_sequencer with TICK_DIV=4, MIN_ON=3,
// DEAD_TIME=2, MAX_ON=6, COOLDOWN=2 (so 1 tick = 4 cycles).
module tb_aq_pump_sequencer;

    logic       clk = 1'b0;
    logic       clr, req_hot, req_cold, water_ok;
    logic       pump_hot, pump_cold, conflict, dry_fault;
    logic [2:0] state;
    logic       both_seen = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n;

    aq_pump_sequencer #(
        .TICK_DIV(4), .MIN_ON(3), .DEAD_TIME(2), .MAX_ON(6), .COOLDOWN(2)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_hot   (req_hot),
        .req_cold  (req_cold),
        .water_ok  (water_ok),
        .pump_hot  (pump_hot),
        .pump_cold (pump_cold),
        .conflict  (conflict),
        .dry_fault (dry_fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pump_hot && pump_cold) both_seen <= 1'b1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts samples while state stays at st; bounded.
    task automatic run_len(input logic [2:0] st, output int len);
        len = 0;
        while (state == st && len < 200) begin
            len++;
            step();
        end
    endtask

    // Counts samples while the chosen pump is on; drops its request at drop_at.
    task automatic pump_len(input bit hot, input int drop_at, output int len);
        len = 0;
        while ((hot ? pump_hot : pump_cold) && len < 200) begin
            len++;
            if (len == drop_at) begin
                if (hot) req_hot = 1'b0;
                else     req_cold = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        clr = 1'b1; req_hot = 1'b0; req_cold = 1'b0; water_ok = 1'b1;
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_pump_hot", pump_hot, 0);
        check("rst_pump_cold", pump_cold, 0);
        check("rst_dry", dry_fault, 0);
        check("rst_conflict", conflict, 0);
        clr = 1'b0;
        repeat (6) step();

        // basic hot run: request dropped before MIN_ON
        req_hot = 1'b1;
        step();
        check("basic_entry_state", state, 1);
        check("basic_cold_off", pump_cold, 0);
        pump_len(1'b1, 4, n);
        check("basic_hot_len", n, 12);
        check("basic_dead_state", state, 3);
        run_len(3'd3, n);
        check("basic_dead_len", n, 8);
        check("basic_idle", state, 0);

        // MAX_ON with request held
        req_cold = 1'b1;
        step();
        check("max_entry_state", state, 2);
        pump_len(1'b0, 0, n);
        check("max_cold_len", n, 24);
        check("max_cool_state", state, 4);
        check("max_cool_pumps", {pump_hot, pump_cold}, 0);
        run_len(3'd4, n);
        check("max_cool_len", n, 8);
        check("max_via_idle", state, 0);
        step();
        check("max_rerun_state", state, 2);
        check("max_rerun_pump", pump_cold, 1);
        req_cold = 1'b0;
        pump_len(1'b0, 0, n);
        check("max_rerun_min_on", n, 12);
        run_len(3'd3, n);
        check("max_rerun_dead_len", n, 8);

        // interlock at count=1
        req_hot = 1'b1;
        step();
        check("ilk_entry_state", state, 1);
        repeat (5) step();
        water_ok = 1'b0;
        req_hot = 1'b0;
        step();
        check("ilk_pump_off", pump_hot, 0);
        check("ilk_dry_set", dry_fault, 1);
        check("ilk_dead_state", state, 3);
        run_len(3'd3, n);
        check("ilk_dead_len", n, 8);
        check("ilk_dry_in_dead_exit", dry_fault, 1);
        step();
        check("ilk_dry_idle_dry", dry_fault, 1);
        water_ok = 1'b1;
        step();
        check("ilk_dry_cleared", dry_fault, 0);
        check("ilk_idle", state, 0);

        // conflict
        req_hot = 1'b1; req_cold = 1'b1;
        #1;
        check("cfl_comb", conflict, 1);
        step();
        check("cfl_held", conflict, 1);
        check("cfl_state", state, 0);
        check("cfl_pumps", {pump_hot, pump_cold}, 0);
        req_cold = 1'b0;
        #1;
        check("cfl_drop", conflict, 0);
        step();
        check("cfl_run_hot", state, 1);
        check("cfl_pump_hot", pump_hot, 1);
        check("cfl_after", conflict, 0);

        // switchover after MIN_ON
        repeat (13) step();
        check("sw_still_hot", pump_hot, 1);
        req_cold = 1'b1;
        step();
        check("sw_dead_state", state, 3);
        check("sw_pumps_off", {pump_hot, pump_cold}, 0);
        run_len(3'd3, n);
        check("sw_dead_len", n, 8);
        check("sw_idle", state, 0);
        check("sw_conflict", conflict, 1);
        check("sw_idle_pumps", {pump_hot, pump_cold}, 0);

        // async clear mid-run
        req_hot = 1'b0;
        step();
        check("clr_run_cold", state, 2);
        repeat (3) step();
        check("clr_pre_pump", pump_cold, 1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_pump_drop", pump_cold, 0);
        check("clr_state", state, 0);
        #2;
        clr = 1'b0;
        step();
        check("clr_rerun_state", state, 2);
        pump_len(1'b0, 2, n);
        check("clr_rerun_len", n, 12);
        run_len(3'd3, n);
        check("clr_rerun_dead_len", n, 8);

        check("never_both", both_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
